// File: rtl/genius_pkg.sv
// Shared definitions for the memory game: FSM state codes (also decoded on the
// 7-segment debug display) and the sequence memory geometry.
package genius_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    FIM     = 4'd4
  } estado_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with async clear, sync clear and enable; fim flags the
// terminal count M-1 so a state can end on its last cycle.
module contador_m #(
  parameter int M = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (zera_s) begin
      q <= '0;
    end else if (conta) begin
      if (q == W'(M - 1)) q <= '0;
      else                q <= q + W'(1);
    end
  end

  assign fim = (q == W'(M - 1));

endmodule

// File: rtl/exibe_sequencia.sv
// Playback of the stored sequence on the LEDs: items 0..rodada, each lit for
// T_ON cycles after a one-cycle RAM settle, followed by a T_OFF dark gap.
module exibe_sequencia
  import genius_pkg::*;
#(
  parameter int T_ON  = 500,
  parameter int T_OFF = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              parar,
  input  logic [ADDR_W-1:0] rodada,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  estado_t           estado, proximo;
  logic [ADDR_W-1:0] endereco;
  logic [ADDR_W-1:0] rodada_reg;
  logic              fim_on, fim_off;
  logic              zera_on, zera_off;
  logic              conta_on, conta_off;
  logic              partida;
  logic              ultimo_item;

  assign partida     = (estado == IDLE) && iniciar && !parar;
  assign ultimo_item = (endereco == rodada_reg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= IDLE;
    else       estado <= proximo;
  end

  // parar overrides every transition out of a non-IDLE state.
  always_comb begin
    proximo = estado;
    case (estado)
      IDLE:    if (partida) proximo = CARREGA;
      CARREGA: proximo = ACESO;
      ACESO:   if (fim_on) proximo = APAGADO;
      APAGADO: if (fim_off) proximo = ultimo_item ? FIM : CARREGA;
      FIM:     proximo = IDLE;
      default: proximo = IDLE;
    endcase
    if (estado != IDLE && parar) proximo = IDLE;
  end

  always_comb begin
    leds      = (estado == ACESO) ? mem_dado : '0;
    exibindo  = (estado != IDLE);
    pronto    = (estado == FIM);
    db_estado = estado;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco   <= '0;
      rodada_reg <= '0;
    end else if (partida) begin
      endereco   <= '0;
      rodada_reg <= rodada;
    end else if (estado == APAGADO && fim_off && !parar && !ultimo_item) begin
      endereco   <= endereco + ADDR_W'(1);
    end
  end

  assign mem_endereco = endereco;

  // Each timer is cleared on the cycle its state is being entered.
  assign zera_on   = (proximo == ACESO)   && (estado != ACESO);
  assign zera_off  = (proximo == APAGADO) && (estado != APAGADO);
  assign conta_on  = (estado == ACESO);
  assign conta_off = (estado == APAGADO);

  contador_m #(.M(T_ON)) u_timer_on (
    .clock  (clock),
    .reset  (reset),
    .zera_s (zera_on),
    .conta  (conta_on),
    .fim    (fim_on)
  );

  contador_m #(.M(T_OFF)) u_timer_off (
    .clock  (clock),
    .reset  (reset),
    .zera_s (zera_off),
    .conta  (conta_off),
    .fim    (fim_off)
  );

endmodule
